matmul_sequencer: RTL and testbench
===================================

# matmul_sequencer

Sequences one N×N matrix multiply C = A·B over the operand buffers filled by the UART receive path. It walks the row (i), column (j) and inner (k) indices, issues synchronous reads to the A and B buffers, and accumulates products in a single multiply-accumulate. Each finished element is written to the result buffer, then done is pulsed. The block is the compute engine behind the top-level controller's mult_start/mult_done handshake.

## Interface
- DATA_W, 8: operand width, unsigned
- ACC_W, 16: accumulator and result width (2 bytes per result element)
- ADDR_W, 8: buffer address width; must hold 15·15−1 = 224
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  level request (mult_start); sampled only in IDLE while armed
- size  input  4  matrix dimension N (0..15); latched on accepted start
- a_rdata  input  DATA_W  A buffer read data, valid the cycle after a_rd_en
- b_rdata  input  DATA_W  B buffer read data, valid the cycle after b_rd_en
- a_rd_en / b_rd_en  output  1  read strobes for the A/B buffers
- a_addr / b_addr  output  ADDR_W  row-major read addresses
- c_wr_en  output  1  result write strobe
- c_addr  output  ADDR_W  result address i·N+j
- c_wdata  output  ACC_W  result data
- busy  output  1  high from accepted start until DONE inclusive
- done  output  1  one-cycle completion pulse (mult_done)

## Operation
- States: IDLE, CLEAR, READ, MAC, WRITE, DONE, HOLD.
- IDLE: if start && armed, latch N := size and set i=j=k=0. Go to CLEAR, or to DONE if N==0.
- CLEAR: acc := 0, k := 0; go to READ.
- READ: a_rd_en=b_rd_en=1, a_addr=i·N+k, b_addr=k·N+j; go to MAC.
- MAC: acc := acc + a_rdata·b_rdata. Product is 2·DATA_W bits, zero-extended; the sum wraps modulo 2^ACC_W with no saturation. If k==N−1 go to WRITE, else k := k+1 and go to READ.
- WRITE: c_wr_en=1, c_addr=i·N+j, c_wdata=acc. Then advance j, wrapping to 0 and incrementing i at N−1. If i==N−1 and j==N−1 go to DONE, else go to CLEAR.
- DONE: done=1 for exactly one cycle; go to HOLD.
- HOLD: clear armed while start is high; return to IDLE once start is low. A start held high across completion never retriggers.
- Addresses are generated with incremental adders (a: base i·N plus k; b: step +N per k). No multiplier on the address path.
- Deasserting start mid-run is ignored; the run always completes.
- A, B and C use the same row-major layout: element (r,c) is at address r·N+c.

## Timing
- Reset values: all strobes 0, addresses 0, c_wdata 0, busy 0, done 0, state IDLE, armed 1, acc 0, N 0.
- Reset asserted mid-run: everything returns to reset values immediately. The pending write is lost, and no done pulse is issued.
- Every output is a function of registered state only; no combinational path from any input to any output.
- Cost per result element is 2N+2 cycles (CLEAR + N·(READ+MAC) + WRITE).
- done is high in cycle N²·(2N+2) after the IDLE→CLEAR transition edge. This is 24 cycles for N=2, 72 for N=3, and 4 for N=1.
- For N==0, done is high in the cycle after start is accepted, and no reads or writes are issued.
- Read data is consumed exactly one cycle after its strobe. The buffers must be synchronous-read with latency 1.
- Exactly N² c_wr_en pulses occur per run, in ascending c_addr order 0..N²−1.

## Test plan
- 2×2: A=[1,2,3,4], B=[5,6,7,8]. Expect writes C[0..3]=19,22,43,50 in that order, and done 24 cycles after leaving IDLE.
- 3×3 identity: A=I, B=[1..9]. Expect C=[1..9], 9 writes, and done at cycle 72.
- Overflow: N=3 with all operands 255. Every C element is 195075 mod 65536 = 64003 (0xFA03).
- size=0: no rd_en or wr_en pulses; done pulses one cycle after start; busy clears after that.
- Reset mid-run: assert rst during element 2 of a 3×3 run. All outputs go to 0 at once. A following 2×2 run then produces correct results.
- Held start: keep start high for 10 cycles after done. Expect no second run. Drop start, then raise it again; expect exactly one new run.

Source files
------------

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: sequences one NxN matrix multiply C = A*B using a single
// multiply-accumulate over synchronous-read (latency 1) operand buffers.
// Row/column/inner indices are walked with incremental address adders.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for an armed start; latches N
//   CLEAR | zero accumulator, load read pointers for element (i,j)
//   READ  | read strobes high, A/B addresses valid
//   MAC   | accumulate a_rdata*b_rdata; advance k or finish element
//   WRITE | result strobe high for element (i,j); advance j/i
//   DONE  | one-cycle completion pulse
//   HOLD  | wait for start to drop so a held start cannot retrigger
module matmul_sequencer #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [3:0]        size_i,
  input  logic [DATA_W-1:0] a_rdata_i,
  input  logic [DATA_W-1:0] b_rdata_i,
  output logic              a_rd_en_o,
  output logic              b_rd_en_o,
  output logic [ADDR_W-1:0] a_addr_o,
  output logic [ADDR_W-1:0] b_addr_o,
  output logic              c_wr_en_o,
  output logic [ADDR_W-1:0] c_addr_o,
  output logic [ACC_W-1:0]  c_wdata_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_READ, S_MAC, S_WRITE, S_DONE, S_HOLD
  } state_t;

  state_t              state_q;
  logic                armed_q;
  logic [3:0]          n_q;
  logic [3:0]          i_q, j_q, k_q;
  logic [ADDR_W-1:0]   a_base_q;
  logic [ACC_W-1:0]    acc_q;
  logic                a_rd_en_q, b_rd_en_q, c_wr_en_q, busy_q, done_q;
  logic [ADDR_W-1:0]   a_addr_q, b_addr_q, c_addr_q;
  logic [ACC_W-1:0]    c_wdata_q;

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    acc_d;
  logic [ADDR_W-1:0]   n_ext;
  logic [3:0]          n_last;

  // Product is zero-extended; the running sum wraps modulo 2^ACC_W
  always_comb begin
    prod   = {{DATA_W{1'b0}}, a_rdata_i} * {{DATA_W{1'b0}}, b_rdata_i};
    acc_d  = acc_q + ACC_W'(prod);
    n_ext  = ADDR_W'(n_q);
    n_last = n_q - 4'd1;
  end

  // Sequencer FSM with all outputs registered alongside the state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      armed_q   <= 1'b1;
      n_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      a_base_q  <= '0;
      acc_q     <= '0;
      a_rd_en_q <= 1'b0;
      b_rd_en_q <= 1'b0;
      c_wr_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      a_addr_q  <= '0;
      b_addr_q  <= '0;
      c_addr_q  <= '0;
      c_wdata_q <= '0;
    end else begin
      a_rd_en_q <= 1'b0;
      b_rd_en_q <= 1'b0;
      c_wr_en_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i && armed_q) begin
            n_q      <= size_i;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            a_base_q <= '0;
            c_addr_q <= '0;
            busy_q   <= 1'b1;
            if (size_i == 4'd0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          acc_q     <= '0;
          k_q       <= '0;
          a_addr_q  <= a_base_q;
          b_addr_q  <= ADDR_W'(j_q);
          a_rd_en_q <= 1'b1;
          b_rd_en_q <= 1'b1;
          state_q   <= S_READ;
        end
        S_READ: begin
          state_q <= S_MAC;
        end
        S_MAC: begin
          acc_q <= acc_d;
          if (k_q == n_last) begin
            c_wr_en_q <= 1'b1;
            c_wdata_q <= acc_d;
            state_q   <= S_WRITE;
          end else begin
            k_q       <= k_q + 4'd1;
            a_addr_q  <= a_addr_q + 1'b1;
            b_addr_q  <= b_addr_q + n_ext;
            a_rd_en_q <= 1'b1;
            b_rd_en_q <= 1'b1;
            state_q   <= S_READ;
          end
        end
        S_WRITE: begin
          // c_addr advances after each write, giving i*N+j without a multiplier
          c_addr_q <= c_addr_q + 1'b1;
          if (j_q == n_last) begin
            j_q      <= '0;
            i_q      <= i_q + 4'd1;
            a_base_q <= a_base_q + n_ext;
          end else begin
            j_q <= j_q + 4'd1;
          end
          if ((i_q == n_last) && (j_q == n_last)) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_CLEAR;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          if (start_i) begin
            armed_q <= 1'b0;
          end else begin
            armed_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign a_rd_en_o = a_rd_en_q;
  assign b_rd_en_o = b_rd_en_q;
  assign a_addr_o  = a_addr_q;
  assign b_addr_o  = b_addr_q;
  assign c_wr_en_o = c_wr_en_q;
  assign c_addr_o  = c_addr_q;
  assign c_wdata_o = c_wdata_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer with latency-1 buffer models.
module tb_matmul_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  size;
  logic [7:0]  a_rdata, b_rdata;
  logic        a_rd_en, b_rd_en, c_wr_en, busy, done;
  logic [7:0]  a_addr, b_addr, c_addr;
  logic [15:0] c_wdata;

  logic [7:0]  amem [0:255];
  logic [7:0]  bmem [0:255];
  int          wr_addr[$];
  int          wr_data[$];
  int          rd_cnt;
  int          chk_cnt = 0;
  int          pass_cnt = 0;

  always #5 clk = ~clk;

  matmul_sequencer dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .size_i(size),
    .a_rdata_i(a_rdata), .b_rdata_i(b_rdata),
    .a_rd_en_o(a_rd_en), .b_rd_en_o(b_rd_en),
    .a_addr_o(a_addr), .b_addr_o(b_addr),
    .c_wr_en_o(c_wr_en), .c_addr_o(c_addr), .c_wdata_o(c_wdata),
    .busy_o(busy), .done_o(done)
  );

  always @(posedge clk) begin
    if (a_rd_en === 1'b1) a_rdata <= amem[a_addr];
    if (b_rd_en === 1'b1) b_rdata <= bmem[b_addr];
    if (a_rd_en === 1'b1 || b_rd_en === 1'b1) rd_cnt <= rd_cnt + 1;
    if (c_wr_en === 1'b1) begin
      wr_addr.push_back(int'(c_addr));
      wr_data.push_back(int'(c_wdata));
    end
  end

  // Runs one multiply; reports done cycle (cycle 0 = first cycle after acceptance)
  task automatic do_run(input int n, input bit hold, output int dcyc,
                        output logic done_next, output logic busy_at, output logic busy_next);
    dcyc = -1;
    wr_addr.delete();
    wr_data.delete();
    rd_cnt = 0;
    @(negedge clk);
    size  = 4'(n);
    start = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dcyc = c;
        break;
      end
    end
    busy_at = busy;
    if (!hold) start = 1'b0;
    @(negedge clk);
    done_next = done;
    busy_next = busy;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; size = 4'd0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({a_rd_en, b_rd_en, c_wr_en, busy, done, a_addr, b_addr, c_addr, c_wdata} !== '0)
      $display("FAIL reset_outputs got rd=%b%b wr=%b busy=%b done=%b aa=%0d ba=%0d ca=%0d cd=%0d want all 0",
               a_rd_en, b_rd_en, c_wr_en, busy, done, a_addr, b_addr, c_addr, c_wdata);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_2x2();
    int d; logic dn, ba, bn;
    int exp_c[4] = '{19, 22, 43, 50};
    amem[0] = 1; amem[1] = 2; amem[2] = 3; amem[3] = 4;
    bmem[0] = 5; bmem[1] = 6; bmem[2] = 7; bmem[3] = 8;
    do_run(2, 1'b0, d, dn, ba, bn);
    chk_cnt++;
    if (d !== 24) $display("FAIL 2x2_done_cycle got %0d want 24", d); else pass_cnt++;
    chk_cnt++;
    if (wr_addr.size() !== 4) $display("FAIL 2x2_write_count got %0d want 4", wr_addr.size());
    else pass_cnt++;
    for (int e = 0; e < 4 && e < wr_addr.size(); e++) begin
      chk_cnt++;
      if (wr_addr[e] !== e || wr_data[e] !== exp_c[e])
        $display("FAIL 2x2_elem%0d got addr %0d data %0d want addr %0d data %0d",
                 e, wr_addr[e], wr_data[e], e, exp_c[e]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (rd_cnt !== 8) $display("FAIL 2x2_read_count got %0d want 8", rd_cnt); else pass_cnt++;
    chk_cnt++;
    if ({ba, dn, bn} !== 3'b100)
      $display("FAIL 2x2_done_pulse got busy_at=%b done_next=%b busy_next=%b want 1 0 0", ba, dn, bn);
    else pass_cnt++;
  endtask

  task automatic test_identity();
    int d; logic dn, ba, bn;
    for (int r = 0; r < 9; r++) begin
      amem[r] = ((r % 4) == 0) ? 8'd1 : 8'd0;
      bmem[r] = 8'(r + 1);
    end
    do_run(3, 1'b0, d, dn, ba, bn);
    chk_cnt++;
    if (d !== 72) $display("FAIL ident_done_cycle got %0d want 72", d); else pass_cnt++;
    chk_cnt++;
    if (wr_addr.size() !== 9) $display("FAIL ident_write_count got %0d want 9", wr_addr.size());
    else pass_cnt++;
    for (int e = 0; e < 9 && e < wr_addr.size(); e++) begin
      chk_cnt++;
      if (wr_addr[e] !== e || wr_data[e] !== e + 1)
        $display("FAIL ident_elem%0d got addr %0d data %0d want addr %0d data %0d",
                 e, wr_addr[e], wr_data[e], e, e + 1);
      else pass_cnt++;
    end
  endtask

  task automatic test_overflow();
    int d; logic dn, ba, bn;
    int bad;
    for (int r = 0; r < 9; r++) begin
      amem[r] = 8'd255;
      bmem[r] = 8'd255;
    end
    do_run(3, 1'b0, d, dn, ba, bn);
    bad = 0;
    for (int e = 0; e < wr_data.size(); e++) if (wr_data[e] !== 64003) bad++;
    chk_cnt++;
    if (wr_data.size() !== 9 || bad !== 0)
      $display("FAIL overflow_wrap got %0d writes, %0d wrong (first %0d) want 9 writes of 64003",
               wr_data.size(), bad, (wr_data.size() > 0) ? wr_data[0] : -1);
    else pass_cnt++;
  endtask

  task automatic test_size0();
    int d; logic dn, ba, bn;
    do_run(0, 1'b0, d, dn, ba, bn);
    chk_cnt++;
    if (d !== 0) $display("FAIL size0_done_cycle got %0d want 0", d); else pass_cnt++;
    chk_cnt++;
    if (rd_cnt !== 0 || wr_addr.size() !== 0)
      $display("FAIL size0_no_access got reads %0d writes %0d want 0 0", rd_cnt, wr_addr.size());
    else pass_cnt++;
    chk_cnt++;
    if ({ba, dn, bn} !== 3'b100)
      $display("FAIL size0_busy got busy_at=%b done_next=%b busy_next=%b want 1 0 0", ba, dn, bn);
    else pass_cnt++;
  endtask

  task automatic test_reset_midrun();
    int d; logic dn, ba, bn;
    bit seen_done;
    int c;
    for (int r = 0; r < 9; r++) begin amem[r] = 8'(r + 1); bmem[r] = 8'(r + 2); end
    wr_addr.delete(); wr_data.delete();
    seen_done = 0;
    @(negedge clk);
    size = 4'd3; start = 1'b1;
    for (c = 0; c < 500 && wr_addr.size() < 2; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1;
    end
    chk_cnt++;
    if (wr_addr.size() !== 2) $display("FAIL midrun_reach_elem2 got %0d writes want 2", wr_addr.size());
    else pass_cnt++;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_cnt++;
    if ({a_rd_en, b_rd_en, c_wr_en, busy, done, a_addr, b_addr, c_addr, c_wdata} !== '0)
      $display("FAIL midrun_async_clear got rd=%b%b wr=%b busy=%b done=%b aa=%0d ba=%0d ca=%0d cd=%0d want all 0",
               a_rd_en, b_rd_en, c_wr_en, busy, done, a_addr, b_addr, c_addr, c_wdata);
    else pass_cnt++;
    chk_cnt++;
    if (seen_done || wr_addr.size() !== 2)
      $display("FAIL midrun_no_done got done_seen=%0d writes=%0d want 0 2", seen_done, wr_addr.size());
    else pass_cnt++;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    amem[0] = 1; amem[1] = 2; amem[2] = 3; amem[3] = 4;
    bmem[0] = 5; bmem[1] = 6; bmem[2] = 7; bmem[3] = 8;
    do_run(2, 1'b0, d, dn, ba, bn);
    chk_cnt++;
    if (d !== 24 || wr_data.size() !== 4 ||
        (wr_data.size() == 4 && (wr_data[0] !== 19 || wr_data[1] !== 22 ||
                                 wr_data[2] !== 43 || wr_data[3] !== 50)))
      $display("FAIL midrun_rerun got done %0d, %0d writes, last %0d want 24, 4, 50",
               d, wr_data.size(), (wr_data.size() > 0) ? wr_data[wr_data.size()-1] : -1);
    else pass_cnt++;
  endtask

  task automatic test_held_start();
    int d; logic dn, ba, bn;
    do_run(1, 1'b1, d, dn, ba, bn);
    chk_cnt++;
    if (d !== 4) $display("FAIL held_first_done got %0d want 4", d); else pass_cnt++;
    rd_cnt = 0;
    wr_addr.delete();
    begin
      int extra_done = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (done === 1'b1 || busy === 1'b1) extra_done++;
      end
      chk_cnt++;
      if (extra_done !== 0 || rd_cnt !== 0 || wr_addr.size() !== 0)
        $display("FAIL held_no_retrigger got busy/done cycles %0d reads %0d writes %0d want 0 0 0",
                 extra_done, rd_cnt, wr_addr.size());
      else pass_cnt++;
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    amem[0] = 8'd7; bmem[0] = 8'd9;
    do_run(1, 1'b0, d, dn, ba, bn);
    chk_cnt++;
    if (d !== 4 || wr_data.size() !== 1 || (wr_data.size() == 1 && wr_data[0] !== 63))
      $display("FAIL held_rearm_run got done %0d writes %0d want 4 1 (data 63)", d, wr_data.size());
    else pass_cnt++;
  endtask

  initial begin
    a_rdata = '0; b_rdata = '0; rd_cnt = 0;
    test_reset();
    test_2x2();
    test_identity();
    test_overflow();
    test_size0();
    test_reset_midrun();
    test_held_start();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
